// File: rtl/turn_signal_conditioner.sv
// turn_signal_conditioner
//
// Front end for the tail-light sequencer. Each raw turn switch goes through a
// two-flop synchronizer and a four-state debounce FSM. The debounced levels
// are resolved into clean Left/Right requests plus a conflict flag. A tick
// divider paces the sequencer while either request is active.
//
// Optional feature (macro TURN_SIGNAL_HAZARD_EN): when both sides are held,
// Left and Right are both driven high (hazard) instead of both low, and the
// tick counter keeps running across single-side/hazard transitions.
//
// Ports:
//   clk       in   system clock, all state on rising edge
//   reset     in   asynchronous active-high reset
//   left_raw  in   raw left switch, asynchronous, may bounce
//   right_raw in   raw right switch, asynchronous, may bounce
//   Left      out  clean left request (registered)
//   Right     out  clean right request (registered)
//   tick      out  one-cycle step enable (registered)
//   conflict  out  both debounced inputs active (registered)

module turn_signal_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned TICK_DIV        = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic left_raw,
    input  logic right_raw,
    output logic Left,
    output logic Right,
    output logic tick,
    output logic conflict
);

    localparam logic [7:0]  DbLimit  = 8'(DEBOUNCE_CYCLES);
    localparam logic [15:0] TickLast = 16'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        StIdle,
        StPressWait,
        StHeld,
        StReleaseWait
    } db_state_e;

    // Bit 0 is the left channel, bit 1 the right channel.
    logic [1:0] raw;
    logic [1:0] sync1_q;
    logic [1:0] sync2_q;

    db_state_e  state_q [2];
    db_state_e  state_d [2];
    logic [7:0] cnt_q   [2];
    logic [7:0] cnt_d   [2];
    logic [1:0] db;

    logic        left_q, left_d;
    logic        right_q, right_d;
    logic        conflict_q, conflict_d;
    logic        tick_q, tick_d;
    logic [15:0] tick_cnt_q, tick_cnt_d;

    assign raw = {right_raw, left_raw};

    // Synchronizer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce FSM state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= StIdle;
                cnt_q[i]   <= 8'd0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Debounce FSM next state. The count holds how many consecutive samples
    // of the new level have been seen; the transition fires on the sample that
    // brings it to DbLimit, so the count never exceeds DbLimit - 1.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            unique case (state_q[i])
                StIdle: begin
                    if (sync2_q[i]) begin
                        if (DbLimit <= 8'd1) begin
                            state_d[i] = StHeld;
                            cnt_d[i]   = 8'd0;
                        end else begin
                            state_d[i] = StPressWait;
                            cnt_d[i]   = 8'd1;
                        end
                    end
                end
                StPressWait: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = StIdle;
                        cnt_d[i]   = 8'd0;
                    end else if (cnt_q[i] >= DbLimit - 8'd1) begin
                        state_d[i] = StHeld;
                        cnt_d[i]   = 8'd0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 8'd1;
                    end
                end
                StHeld: begin
                    if (!sync2_q[i]) begin
                        if (DbLimit <= 8'd1) begin
                            state_d[i] = StIdle;
                            cnt_d[i]   = 8'd0;
                        end else begin
                            state_d[i] = StReleaseWait;
                            cnt_d[i]   = 8'd1;
                        end
                    end
                end
                StReleaseWait: begin
                    if (sync2_q[i]) begin
                        state_d[i] = StHeld;
                        cnt_d[i]   = 8'd0;
                    end else if (cnt_q[i] >= DbLimit - 8'd1) begin
                        state_d[i] = StIdle;
                        cnt_d[i]   = 8'd0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 8'd1;
                    end
                end
                default: begin
                    state_d[i] = StIdle;
                    cnt_d[i]   = 8'd0;
                end
            endcase
        end
    end

    // Debounced level is high from the moment the press completes until the
    // release completes.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            db[i] = (state_q[i] == StHeld) || (state_q[i] == StReleaseWait);
        end
    end

    // Resolution
    always_comb begin
        conflict_d = db[0] & db[1];
`ifdef TURN_SIGNAL_HAZARD_EN
        left_d     = db[0];
        right_d    = db[1];
`else
        left_d     = db[0] & ~db[1];
        right_d    = db[1] & ~db[0];
`endif
    end

    // Tick divider. The counter sits at 0 while no request is active, so a
    // rising request always starts a fresh period and the first tick lands
    // TICK_DIV cycles after the request appears.
    always_comb begin
        tick_cnt_d = 16'd0;
        tick_d     = 1'b0;
        if (left_q | right_q) begin
            if (tick_cnt_q >= TickLast) begin
                tick_cnt_d = 16'd0;
                tick_d     = 1'b1;
            end else begin
                tick_cnt_d = tick_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            left_q     <= 1'b0;
            right_q    <= 1'b0;
            conflict_q <= 1'b0;
            tick_q     <= 1'b0;
            tick_cnt_q <= 16'd0;
        end else begin
            left_q     <= left_d;
            right_q    <= right_d;
            conflict_q <= conflict_d;
            tick_q     <= tick_d;
            tick_cnt_q <= tick_cnt_d;
        end
    end

    assign Left     = left_q;
    assign Right    = right_q;
    assign tick     = tick_q;
    assign conflict = conflict_q;

endmodule
